// File: rtl/planificador_pkg.sv
// Shared definitions for the two-channel filter scheduler: state encoding,
// MAC step indices, history-select codes and default MAC hold time.
package planificador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_MAC0  = 3'd2,
    ST_MAC1  = 3'd3,
    ST_MAC2  = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] STEP_0 = 2'd0;
  localparam logic [1:0] STEP_1 = 2'd1;
  localparam logic [1:0] STEP_2 = 2'd2;
  localparam logic [1:0] STEP_3 = 2'd3;

  localparam logic [1:0] FK_0 = 2'd0;
  localparam logic [1:0] FK_1 = 2'd1;
  localparam logic [1:0] FK_2 = 2'd2;

  localparam int unsigned MAC_WAIT_DEF = 1;

  // Coefficient step index used while in a MAC state.
  function automatic logic [1:0] mac_step(input state_t st);
    case (st)
      ST_MAC1: mac_step = STEP_1;
      ST_MAC2: mac_step = STEP_2;
      default: mac_step = STEP_0;
    endcase
  endfunction

endpackage

// File: rtl/solicitud_pendiente.sv
// Per-channel request tracking: rising-edge detect of the ADC flag,
// pending request latch and sticky overrun flag.
module solicitud_pendiente (
  input  logic clk,
  input  logic reset,
  input  logic flag,
  input  logic clr,
  input  logic clr_ovr,
  output logic pend,
  output logic overrun
);

  logic prev;
  logic rise;

  assign rise = flag & ~prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev <= flag;
      // A new edge wins over the service clear, so a request arriving in DONE is kept.
      if (rise)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
      if (rise && pend && !clr)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/planificador_filtro.sv
// Round-robin scheduler sharing one MAC datapath between two ADC channels:
// three timed MAC steps, a history shift, then a per-channel ready pulse.
module planificador_filtro
  import planificador_pkg::*;
#(
  parameter int unsigned MAC_WAIT = MAC_WAIT_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Bandera_ADC_0,
  input  logic       Bandera_ADC_1,
  input  logic       Clr_Ovr,
  output logic [2:0] Sel_Const,
  output logic [1:0] Sel_Fk,
  output logic       Sel_Acum,
  output logic       Acum_En,
  output logic       Shift_En,
  output logic       Chan,
  output logic       Busy,
  output logic       Bandera_Listo_0,
  output logic       Bandera_Listo_1,
  output logic       Overrun_0,
  output logic       Overrun_1
);

  localparam logic [3:0] WAIT_LAST = 4'(MAC_WAIT - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       wait_last;
  logic       last_served;
  logic       pend_0, pend_1;
  logic       clr_0, clr_1;
  logic       in_mac;
  logic       grant_ch;

  solicitud_pendiente u_sol_0 (
    .clk     (Clk),
    .reset   (Reset),
    .flag    (Bandera_ADC_0),
    .clr     (clr_0),
    .clr_ovr (Clr_Ovr),
    .pend    (pend_0),
    .overrun (Overrun_0)
  );

  solicitud_pendiente u_sol_1 (
    .clk     (Clk),
    .reset   (Reset),
    .flag    (Bandera_ADC_1),
    .clr     (clr_1),
    .clr_ovr (Clr_Ovr),
    .pend    (pend_1),
    .overrun (Overrun_1)
  );

  assign in_mac    = (state == ST_MAC0) || (state == ST_MAC1) || (state == ST_MAC2);
  assign wait_last = (wait_cnt == WAIT_LAST);
  // With both pending, the channel not served last goes first.
  assign grant_ch  = (pend_0 && pend_1) ? ~last_served : pend_1;

  assign clr_0 = (state == ST_DONE) && !Chan;
  assign clr_1 = (state == ST_DONE) &&  Chan;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      Chan        <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state <= state_next;
      if (in_mac && !wait_last)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
      if (state == ST_GRANT)
        Chan <= grant_ch;
      if (state == ST_DONE)
        last_served <= Chan;
    end
  end

  always_comb begin
    state_next      = state;
    Sel_Const       = '0;
    Sel_Fk          = '0;
    Sel_Acum        = 1'b0;
    Acum_En         = 1'b0;
    Shift_En        = 1'b0;
    Bandera_Listo_0 = 1'b0;
    Bandera_Listo_1 = 1'b0;
    Busy            = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (pend_0 || pend_1) state_next = ST_GRANT;
      ST_GRANT: state_next = ST_MAC0;
      ST_MAC0: begin
        Sel_Fk    = FK_0;
        Sel_Const = {Chan, mac_step(state)};
        Acum_En   = wait_last;
        if (wait_last) state_next = ST_MAC1;
      end
      ST_MAC1: begin
        Sel_Fk    = FK_1;
        Sel_Acum  = 1'b1;
        Sel_Const = {Chan, mac_step(state)};
        Acum_En   = wait_last;
        if (wait_last) state_next = ST_MAC2;
      end
      ST_MAC2: begin
        Sel_Fk    = FK_2;
        Sel_Acum  = 1'b1;
        Sel_Const = {Chan, mac_step(state)};
        Acum_En   = wait_last;
        if (wait_last) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        Shift_En   = 1'b1;
        Sel_Const  = {Chan, STEP_3};
        state_next = ST_DONE;
      end
      ST_DONE: begin
        Bandera_Listo_0 = !Chan;
        Bandera_Listo_1 = Chan;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_planificador_filtro.sv
// Directed bench for planificador_filtro: cycle-by-cycle output vectors for
// single, tied, overrun, reset-abort and MAC_WAIT=3 transactions.
module tb_planificador_filtro;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Bandera_ADC_0 = 1'b0;
  logic       Bandera_ADC_1 = 1'b0;
  logic       Clr_Ovr = 1'b0;

  logic [2:0] sc1, sc3;
  logic [1:0] fk1, fk3;
  logic       sa1, sa3, ae1, ae3, se1, se3, ch1, ch3, bz1, bz3;
  logic       l01, l03, l11, l13, o01, o03, o11, o13;
  logic [13:0] obs1, obs3;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 Clk = ~Clk;

  planificador_filtro dut (
    .Clk(Clk), .Reset(Reset), .Bandera_ADC_0(Bandera_ADC_0), .Bandera_ADC_1(Bandera_ADC_1),
    .Clr_Ovr(Clr_Ovr), .Sel_Const(sc1), .Sel_Fk(fk1), .Sel_Acum(sa1), .Acum_En(ae1),
    .Shift_En(se1), .Chan(ch1), .Busy(bz1), .Bandera_Listo_0(l01), .Bandera_Listo_1(l11),
    .Overrun_0(o01), .Overrun_1(o11)
  );

  planificador_filtro #(.MAC_WAIT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Bandera_ADC_0(Bandera_ADC_0), .Bandera_ADC_1(Bandera_ADC_1),
    .Clr_Ovr(Clr_Ovr), .Sel_Const(sc3), .Sel_Fk(fk3), .Sel_Acum(sa3), .Acum_En(ae3),
    .Shift_En(se3), .Chan(ch3), .Busy(bz3), .Bandera_Listo_0(l03), .Bandera_Listo_1(l13),
    .Overrun_0(o03), .Overrun_1(o13)
  );

  assign obs1 = {sc1, fk1, sa1, ae1, se1, ch1, bz1, l01, l11, o01, o11};
  assign obs3 = {sc3, fk3, sa3, ae3, se3, ch3, bz3, l03, l13, o03, o13};

  function automatic logic [13:0] pk(input logic [2:0] sc, input logic [1:0] fk,
                                     input logic sa, ae, se, ch, bz, l0, l1, o0, o1);
    return {sc, fk, sa, ae, se, ch, bz, l0, l1, o0, o1};
  endfunction

  // Expected outputs at offset off from the GRANT cycle of one transaction.
  function automatic logic [13:0] txn_exp(input int unsigned w, input int unsigned off,
                                          input logic ch, input logic ch_prev,
                                          input logic o0, input logic o1);
    int unsigned k;
    logic [1:0]  k2;
    logic        last;
    if (off == 0) return pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, ch_prev, 1'b1, 1'b0, 1'b0, o0, o1);
    if (off <= 3 * w) begin
      k    = (off - 1) / w;
      k2   = k[1:0];
      last = (((off - 1) % w) == w - 1);
      return pk({ch, k2}, k2, (k != 0), last, 1'b0, ch, 1'b1, 1'b0, 1'b0, o0, o1);
    end
    if (off == 3 * w + 1) return pk({ch, 2'd3}, 2'd0, 1'b0, 1'b0, 1'b1, ch, 1'b1, 1'b0, 1'b0, o0, o1);
    return pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, ch, 1'b1, ~ch, ch, o0, o1);
  endfunction

  function automatic logic [13:0] idle_exp(input logic ch, input logic o0, input logic o1);
    return pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, ch, 1'b0, 1'b0, 1'b0, o0, o1);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Bandera_ADC_0 = 1'b0;
    Bandera_ADC_1 = 1'b0;
    Clr_Ovr = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    // 1: single ch0 pulse, then a new ch0 edge in DONE is kept without overrun
    do_reset();
    chk("reset_w1", obs1, 14'd0);
    chk("reset_w3", obs3, 14'd0);
    Bandera_ADC_0 = 1'b1;
    chk("t1_c0", obs1, idle_exp(1'b0, 1'b0, 1'b0));
    step(); Bandera_ADC_0 = 1'b0;
    chk("t1_c1", obs1, idle_exp(1'b0, 1'b0, 1'b0));
    for (int unsigned off = 0; off <= 5; off++) begin
      step();
      chk($sformatf("t1_off%0d", off), obs1, txn_exp(1, off, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    Bandera_ADC_0 = 1'b1;
    step(); Bandera_ADC_0 = 1'b0;
    chk("t1_c8", obs1, idle_exp(1'b0, 1'b0, 1'b0));
    for (int unsigned off = 0; off <= 5; off++) begin
      step();
      chk($sformatf("t1b_off%0d", off), obs1, txn_exp(1, off, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step();
    chk("t1_end", obs1, idle_exp(1'b0, 1'b0, 1'b0));

    // 2: both flags rise together and stay high
    do_reset();
    Bandera_ADC_0 = 1'b1;
    Bandera_ADC_1 = 1'b1;
    step();
    chk("t2_c1", obs1, idle_exp(1'b0, 1'b0, 1'b0));
    for (int unsigned off = 0; off <= 5; off++) begin
      step();
      chk($sformatf("t2a_off%0d", off), obs1, txn_exp(1, off, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step();
    chk("t2_c8", obs1, idle_exp(1'b0, 1'b0, 1'b0));
    for (int unsigned off = 0; off <= 5; off++) begin
      step();
      chk($sformatf("t2b_off%0d", off), obs1, txn_exp(1, off, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t2_held%0d", i), obs1, idle_exp(1'b1, 1'b0, 1'b0));
    end

    // 3: second ch1 edge during MAC1 -> overrun, single Listo, then Clr_Ovr
    do_reset();
    Bandera_ADC_1 = 1'b1;
    step(); Bandera_ADC_1 = 1'b0;
    for (int unsigned off = 0; off <= 5; off++) begin
      step();
      chk($sformatf("t3_off%0d", off), obs1, txn_exp(1, off, 1'b1, 1'b0, 1'b0, off >= 3));
      if (off == 2) Bandera_ADC_1 = 1'b1;
      if (off == 3) Bandera_ADC_1 = 1'b0;
    end
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_idle%0d", i), obs1, idle_exp(1'b1, 1'b0, 1'b1));
    end
    Clr_Ovr = 1'b1;
    step(); Clr_Ovr = 1'b0;
    chk("t3_clr", obs1, idle_exp(1'b1, 1'b0, 1'b0));

    // 4: reset in MAC2 aborts; a fresh request then completes in 7 cycles
    do_reset();
    Bandera_ADC_0 = 1'b1;
    step(); Bandera_ADC_0 = 1'b0;
    for (int unsigned off = 0; off <= 3; off++) begin
      step();
      chk($sformatf("t4_off%0d", off), obs1, txn_exp(1, off, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    Reset = 1'b1;
    step(); Reset = 1'b0;
    chk("t4_abort", obs1, 14'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_nolisto%0d", i), obs1, idle_exp(1'b0, 1'b0, 1'b0));
    end
    Bandera_ADC_0 = 1'b1;
    step(); Bandera_ADC_0 = 1'b0;
    for (int unsigned off = 0; off <= 5; off++) begin
      step();
      chk($sformatf("t4b_off%0d", off), obs1, txn_exp(1, off, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // 5: MAC_WAIT=3, Listo at cycle 13
    do_reset();
    Bandera_ADC_0 = 1'b1;
    step(); Bandera_ADC_0 = 1'b0;
    chk("t5_c1", obs3, idle_exp(1'b0, 1'b0, 1'b0));
    for (int unsigned off = 0; off <= 11; off++) begin
      step();
      chk($sformatf("t5_off%0d", off), obs3, txn_exp(3, off, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step();
    chk("t5_end", obs3, idle_exp(1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
